// File: rtl/fixed_float_pipe.sv
// fixed_float_pipe: three-stage fixed-point to IEEE-754 single-precision
// converter with signed/unsigned and RNE/truncate selection per transaction.
// The pipeline advances as a whole whenever the output register is empty or
// being drained, so in_ready never depends on in_valid.
module fixed_float_pipe #(
  parameter int W = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_signed,
  input  logic         in_rnd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_inexact,
  output logic         out_zero
);

  // Biased exponent when the leading one already sits at bit W-1.
  localparam logic [7:0] EXP_TOP = 8'(W - 1 - Q + 127);

  // Count of zeros above the leading one; W for a zero input.
  function automatic logic [7:0] lead_zeros(input logic [W-1:0] v);
    logic [7:0] n;
    n = 8'(W);
    for (int i = 0; i < W; i++) begin
      if (v[i]) n = 8'(W - 1 - i);
    end
    return n;
  endfunction

  logic adv;

  // Stage 1 registers: sign, magnitude, rounding mode.
  logic         s1_valid;
  logic         s1_sign;
  logic         s1_rnd;
  logic [W-1:0] s1_mag;

  // Stage 2 registers: normalised magnitude and biased exponent.
  logic         s2_valid;
  logic         s2_sign;
  logic         s2_rnd;
  logic [W-1:0] s2_norm;
  logic [7:0]   s2_exp;

  // Combinational next values.
  logic         s1_neg;
  logic [7:0]   s2_lz;
  logic         s2_zero;
  logic [W+22:0] s3_ext;
  logic [22:0]  s3_man;
  logic         s3_guard;
  logic         s3_sticky;
  logic         s3_inc;
  logic [23:0]  s3_sum;
  logic [7:0]   s3_exp;
  logic [31:0]  s3_data;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 input decode: two's-complement negation in W bits maps the most
  // negative value to 2^(W-1), which fits the unsigned magnitude exactly.
  assign s1_neg = in_signed && in_data[W-1];

  // Stage 2 normalisation: the leading one of a nonzero magnitude lands on
  // bit W-1, so that bit doubles as the nonzero flag further down.
  assign s2_lz   = lead_zeros(s1_mag);
  assign s2_zero = !s2_norm[W-1];

  // Stage 3 round and pack: the implicit one is dropped and 24 zero bits are
  // appended so narrow inputs pad the mantissa and guard/sticky read as 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    s3_ext    = {s2_norm[W-2:0], 24'b0};
    s3_man    = s3_ext[W+22:W];
    s3_guard  = s3_ext[W-1];
    s3_sticky = |s3_ext[W-2:0];
    s3_inc    = s2_rnd && s3_guard && (s3_sticky || s3_man[0]);
    s3_sum    = {1'b0, s3_man} + {23'b0, s3_inc};
    s3_exp    = s2_exp + {7'b0, s3_sum[23]};
    s3_data   = {s2_sign, s3_exp, s3_sum[22:0]};
    if (s2_zero) s3_data = 32'h0000_0000;
  end

  // Control and output registers: valid bits and everything visible outside.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 32'h0000_0000;
      out_inexact <= 1'b0;
      out_zero    <= 1'b0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s2_valid    <= s1_valid;
      out_valid   <= s2_valid;
      out_data    <= s3_data;
      out_inexact <= !s2_zero && (s3_guard || s3_sticky);
      out_zero    <= s2_zero;
    end
  end

  // Internal datapath registers: loaded on every advance, bubbles included.
  always_ff @(posedge clk) begin
    // NOTE: these registers carry no reset; their contents only matter when
    // the matching valid bit, which is reset, says so.
    if (adv) begin
      s1_sign <= s1_neg;
      s1_rnd  <= in_rnd;
      s1_mag  <= s1_neg ? -in_data : in_data;
      s2_sign <= s1_sign && (s1_mag != '0);
      s2_rnd  <= s1_rnd;
      s2_norm <= s1_mag << s2_lz;
      s2_exp  <= EXP_TOP - s2_lz;
    end
  end

endmodule

// File: tb/tb_fixed_float_pipe.sv
// tb_fixed_float_pipe: six converters of different (W,Q) share one handshake
// (timing is data-independent), each checked against an arithmetic model.
module tb_fixed_float_pipe;

  localparam int N = 6;
  localparam int WS [N] = '{32, 32, 8, 24, 64, 64};
  localparam int QS [N] = '{16, 0, 4, 0, 32, 63};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        in_rnd = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic [N-1:0] in_ready, out_valid, out_inexact, out_zero;
  logic [31:0] out_data [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    fixed_float_pipe #(.W(WS[g]), .Q(QS[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[WS[g]-1:0]),
      .in_signed  (in_signed),
      .in_rnd     (in_rnd),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .out_data   (out_data[g]),
      .out_inexact(out_inexact[g]),
      .out_zero   (out_zero[g])
    );
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact value mag * 2^-qf, rounded by comparing the discarded
  // remainder against one half ulp. Returns {zero, inexact, float}.
  function automatic logic [33:0] ref_conv(input int w, input int qf, input logic [63:0] d,
                                           input logic sgn, input logic rnd);
    logic [63:0] mask, v, mag, kept, rem, half;
    logic neg, inx;
    int p, s, ex;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = d & mask;
    neg  = sgn && v[w-1];
    mag  = neg ? ((~v + 64'd1) & mask) : v;
    if (mag == 0) return {2'b10, 32'h0};
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    ex  = p - qf + 127;
    inx = 1'b0;
    if (p <= 23) begin
      kept = mag << (23 - p);
    end else begin
      s    = p - 23;
      kept = mag >> s;
      rem  = mag & ((64'd1 << s) - 64'd1);
      half = 64'd1 << (s - 1);
      inx  = (rem != 0);
      if (rnd && (rem > half || (rem == half && kept[0]))) kept = kept + 64'd1;
      if (kept == (64'd1 << 24)) begin
        kept = 64'd1 << 23;
        ex++;
      end
    end
    return {1'b0, inx, neg, ex[7:0], kept[22:0]};
  endfunction

  typedef logic [N-1:0][33:0] exp_t;
  exp_t exp_q[$];

  // Monitor: samples on the falling edge what the next rising edge will see.
  logic        rst_seen = 1'b0;
  logic        stall_prev = 1'b0;
  logic [33:0] held [N];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("reset_state[%0d]", k),
              {out_valid[k], out_inexact[k], out_zero[k], out_data[k]}, '0);
        check($sformatf("reset_in_ready[%0d]", k), in_ready[k], 1'b1);
      end
    end else if (stall_prev) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("stall_valid[%0d]", k), out_valid[k], 1'b1);
        check($sformatf("stall_hold[%0d]", k), {out_inexact[k], out_zero[k], out_data[k]}, held[k]);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      for (int k = 0; k < N; k++)
        check($sformatf("in_ready[%0d]", k), in_ready[k], !(out_valid[k] && !out_ready));
      if (out_valid[0] && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, '0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < N; k++) begin
            check($sformatf("valid[%0d]", k), out_valid[k], 1'b1);
            check($sformatf("result[%0d] W=%0d Q=%0d", k, WS[k], QS[k]),
                  {out_zero[k], out_inexact[k], out_data[k]}, e[k]);
          end
        end
      end
      if (in_valid && in_ready[0]) begin
        for (int k = 0; k < N; k++) e[k] = ref_conv(WS[k], QS[k], in_data, in_signed, in_rnd);
        exp_q.push_back(e);
      end
      stall_prev = out_valid[0] && !out_ready;
      for (int k = 0; k < N; k++) held[k] = {out_inexact[k], out_zero[k], out_data[k]};
    end
    rst_seen = rst_n;
  end

  // Consumer: always ready, pseudo-random, a forced stall window, or held low.
  int   stall_left = 0;
  logic rand_ready = 1'b0;
  logic hold_low = 1'b0;

  always @(posedge clk) begin
    #1;
    if (hold_low) out_ready = 1'b0;
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [63:0] d, input logic s, input logic r);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; in_signed = s; in_rnd = r;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = in_ready[0];
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rand_ready = 1'b0;
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [63:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = 64'd1 << $urandom_range(0, 63);
      3: r = r >> $urandom_range(0, 63);
      default: ;
    endcase
    return r;
  endfunction

  typedef struct {
    int          w;
    int          qf;
    logic [63:0] d;
    logic        s;
    logic        r;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs [9] = '{
    '{32, 16, 64'h0001_0000, 1'b1, 1'b1, {2'b00, 32'h3F80_0000}},
    '{32, 16, 64'hFFFF_0000, 1'b1, 1'b1, {2'b00, 32'hBF80_0000}},
    '{32, 16, 64'h8000_0000, 1'b1, 1'b1, {2'b00, 32'hC700_0000}},
    '{32, 16, 64'h0000_0000, 1'b1, 1'b1, {2'b10, 32'h0000_0000}},
    '{32, 16, 64'h8000_0000, 1'b0, 1'b1, {2'b00, 32'h4700_0000}},
    '{32, 16, 64'h7FFF_FFFF, 1'b1, 1'b1, {2'b01, 32'h4700_0000}},
    '{32, 16, 64'h7FFF_FFFF, 1'b1, 1'b0, {2'b01, 32'h46FF_FFFF}},
    '{32,  0, 64'h0100_0001, 1'b1, 1'b1, {2'b01, 32'h4B80_0000}},
    '{32,  0, 64'h0100_0003, 1'b1, 1'b1, {2'b01, 32'h4B80_0002}}
  };

  initial begin
    int lat;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model against hand-computed results.
    for (int i = 0; i < 9; i++)
      check($sformatf("model_vec%0d", i),
            ref_conv(vecs[i].w, vecs[i].qf, vecs[i].d, vecs[i].s, vecs[i].r), vecs[i].exp);

    // First transaction: latency and literal result.
    send(64'h0001_0000, 1'b1, 1'b1);
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (out_valid[0]) lat = c;
    end
    check("latency", lat, 3);
    check("first_result", {out_inexact[0], out_data[0]}, {1'b0, 32'h3F80_0000});
    idle(4);

    // Directed vectors back-to-back through every width.
    for (int i = 0; i < 9; i++) send(vecs[i].d, vecs[i].s, vecs[i].r);
    idle(6);

    // Random stream with random backpressure and a 5-cycle stall.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) stall_left = 5;
      send(rand_data(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset with three transactions in flight: none may emerge.
    hold_low = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) send(rand_data(), 1'b1, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    idle(2);
    hold_low = 1'b0;
    rst_n = 1'b1;
    idle(10);
    check("flush_queue", exp_q.size(), 0);
    check("flush_valid", out_valid, '0);

    // Recovery after reset.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(rand_data(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_float_pipe.md
# fixed_float_pipe

Pipelined, parametrised fixed-point to IEEE-754 single-precision converter. It replaces the single-cycle 32-bit, truncating converter in the FPU arithmetic path. Adds generic input width, per-transaction signed/unsigned and rounding-mode selection, inexact/zero flags, and a valid/ready handshake with backpressure. Sits between fixed-point datapath producers and the float arithmetic units.

## Interface
- W, 32, fixed-point input width; legal range 8..64.
- Q, 16, fractional bits of the input; legal range 0..W-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  converter can accept the input this cycle.
- in_data  in  W  fixed-point value, Q fractional bits.
- in_signed  in  1  1: in_data is two's complement; 0: unsigned.
- in_rnd  in  1  1: round-to-nearest-even; 0: truncate toward zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  32  IEEE-754 single {sign, exp[7:0], man[22:0]}.
- out_inexact  out  1  result differs from the exact input value.
- out_zero  out  1  input was zero; out_data is +0.0.

## Operation
- Three registered stages, each with its own valid bit.
  - S1: capture sign, magnitude, and in_rnd. For in_signed=1 with MSB=1: sign=1, magnitude = two's-complement negation in W bits. The magnitude of -2^(W-1) is 2^(W-1) unsigned, not overflowed. Otherwise sign=0 and magnitude = in_data.
  - S2: leading-zero count lz over the W-bit magnitude. Normalise by left shift of lz so the leading one sits at bit W-1. Unbiased exponent e = W-1-lz-Q.
  - S3: round and pack. Mantissa = normalised bits [W-2:W-24]; zero-pad on the right when W<24.
    - Guard = next bit below the mantissa. Sticky = OR of all remaining lower bits.
    - inexact = guard | sticky.
    - RNE: increment the mantissa when guard & (sticky | mantissa LSB).
    - A mantissa carry-out sets mantissa=0 and exponent+1.
    - Truncate: no increment.
  - Biased exponent = e + 127. The parameter ranges keep it within 64..191, so no overflow or denormal handling is needed.
- Zero magnitude: out_data = 32'h0000_0000, sign forced 0, out_zero=1, out_inexact=0.
- For W≤24, out_inexact is always 0.
- Unsigned mode never sets the sign bit.

## Timing
- Reset (rst_n=0 at a clk edge): all stage valid bits, out_valid, out_data, out_inexact and out_zero are 0. Any in-flight data is discarded and no partial result is emitted. in_ready is 1 in the first cycle after reset.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational from out_valid and out_ready only; it never depends on in_valid.
- A transfer occurs on a clk edge with valid & ready on the respective side. When adv=1, every stage loads from its predecessor, including bubbles. When adv=0, all stages hold.
- Latency: exactly 3 cycles from input acceptance to out_valid under no backpressure. Throughput is 1 per cycle.
- Outputs remain stable while out_valid=1 and out_ready=0.
- Results leave in input order. There is no loss or duplication under any in_valid/out_ready pattern.
- Simultaneous input accept and output drain in the same cycle is legal and keeps full throughput.
- in_signed and in_rnd are sampled only on input acceptance and travel with the data.

## Test plan
- Reset and basic flow. W=32, Q=16; hold rst_n=0 for 2 cycles, then send 32'h0001_0000 with signed and RNE, out_ready=1.
  - During and after reset, out_valid=0.
  - 3 cycles after acceptance: 32'h3F80_0000, inexact=0.
- Sign and extreme inputs, W=32, Q=16, signed.
  - 32'hFFFF_0000 -> 32'hBF80_0000.
  - 32'h8000_0000 -> 32'hC700_0000.
  - 32'h0000_0000 -> 32'h0000_0000 with zero=1.
  - Unsigned 32'h8000_0000 -> 32'h4700_0000.
- Rounding, W=32, Q=16.
  - 32'h7FFF_FFFF with RNE -> 32'h4700_0000, inexact=1.
  - Same input with truncate -> 32'h46FF_FFFF, inexact=1.
- Tie-to-even, W=32, Q=0, RNE.
  - 32'h0100_0001 -> 32'h4B80_0000, inexact=1.
  - 32'h0100_0003 -> 32'h4B80_0002, inexact=1.
- Backpressure. Stream 20 random inputs back-to-back while toggling out_ready pseudo-randomly and out_ready=0 for 5 consecutive cycles.
  - In-order results match the reference model.
  - Outputs stay stable while stalled.
  - in_ready=0 whenever out_valid=1 and out_ready=0.
- Reset mid-stream and width sweep.
  - Assert rst_n=0 with 3 transactions in flight: none emerge after reset.
  - Repeat the random compare for (W,Q) = (8,4), (24,0), (64,32), (64,63).
